// File: rtl/sram_avalon_ctrl.sv
// Avalon-MM slave that turns single-word reads/writes into asynchronous SRAM bus cycles.
// Read/write strobe lengths, the post-read turnaround gap and the data width are parameters.
module sram_avalon_ctrl #(
    parameter int AW           = 18,
    parameter int DW           = 16,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2,
    parameter int TURNAROUND   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [DW-1:0]      avs_writedata,
    input  logic [DW/8-1:0]    avs_byteenable,
    output logic               avs_waitrequest,
    output logic [DW-1:0]      avs_readdata,
    output logic               avs_readdatavalid,
    output logic [AW-1:0]      sram_addr,
    input  logic [DW-1:0]      sram_dq_read,
    output logic [DW-1:0]      sram_dq_write,
    output logic               sram_dq_en,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [DW/8-1:0]    sram_be_n
);
    localparam int BW      = DW / 8;
    localparam int RW_MAX  = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_MAX = (RW_MAX > TURNAROUND) ? RW_MAX : TURNAROUND;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RD_INIT   = CW'(READ_CYCLES - 1);
    localparam logic [CW-1:0] WR_INIT   = CW'(WRITE_CYCLES - 1);
    localparam logic [CW-1:0] TURN_INIT = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_TURN  = 3'd2,
        S_WRITE = 3'd3,
        S_WHOLD = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cnt_last;
    logic            accept_wr, accept_rd;

    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   dq_write_q, dq_write_d;
    logic            dq_en_q, dq_en_d;
    logic            ce_n_q, ce_n_d;
    logic            oe_n_q, oe_n_d;
    logic            we_n_q, we_n_d;
    logic [BW-1:0]   be_n_q, be_n_d;
    logic [DW-1:0]   readdata_q, readdata_d;
    logic            rdv_q, rdv_d;

    // A simultaneous read and write is resolved in favour of the write.
    assign accept_wr = (state_q == S_IDLE) && avs_write;
    assign accept_rd = (state_q == S_IDLE) && avs_read && !avs_write;
    assign cnt_last  = (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            dq_write_q <= '0;
            dq_en_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= '1;
            readdata_q <= '0;
            rdv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dq_write_q <= dq_write_d;
            dq_en_q    <= dq_en_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
            readdata_q <= readdata_d;
            rdv_q      <= rdv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_wr) begin
                    state_d = S_WRITE;
                    cnt_d   = WR_INIT;
                end else if (accept_rd) begin
                    state_d = S_READ;
                    cnt_d   = RD_INIT;
                end
            end
            S_READ: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (TURNAROUND > 0) begin
                    state_d = S_TURN;
                    cnt_d   = TURN_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                if (cnt_last) state_d = S_IDLE;
                else          cnt_d   = cnt_q - CW'(1);
            end
            S_WRITE: begin
                if (cnt_last) state_d = S_WHOLD;
                else          cnt_d   = cnt_q - CW'(1);
            end
            S_WHOLD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so their next values follow the next state.
    always_comb begin
        ce_n_d     = 1'b1;
        oe_n_d     = 1'b1;
        we_n_d     = 1'b1;
        be_n_d     = '1;
        dq_en_d    = 1'b0;
        addr_d     = addr_q;
        dq_write_d = dq_write_q;
        readdata_d = readdata_q;
        rdv_d      = 1'b0;

        if (accept_wr || accept_rd) addr_d = avs_address;
        if (accept_wr) dq_write_d = avs_writedata;

        case (state_d)
            S_READ: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            S_WRITE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_en_d = 1'b1;
                be_n_d  = accept_wr ? ~avs_byteenable : be_n_q;
            end
            S_WHOLD: begin
                ce_n_d  = 1'b0;
                dq_en_d = 1'b1;
                be_n_d  = be_n_q;
            end
            default: ;
        endcase

        if (state_q == S_READ && cnt_last) begin
            readdata_d = sram_dq_read;
            rdv_d      = 1'b1;
        end
    end

    assign avs_waitrequest   = reset || (state_q != S_IDLE);
    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = rdv_q;
    assign sram_addr         = addr_q;
    assign sram_dq_write     = dq_write_q;
    assign sram_dq_en        = dq_en_q;
    assign sram_ce_n         = ce_n_q;
    assign sram_oe_n         = oe_n_q;
    assign sram_we_n         = we_n_q;
    assign sram_be_n         = be_n_q;

endmodule

// File: tb/tb_sram_avalon_ctrl.sv
// Directed and random checks of sram_avalon_ctrl against behavioural async SRAM models.
// Two instances: default 16-bit part, and a 32-bit / 20-bit-address / zero-turnaround variant.
module tb_sram_avalon_ctrl;
    localparam int AW1 = 18, DW1 = 16, BW1 = 2, RC1 = 2, WC1 = 2, TA1 = 1;
    localparam int AW2 = 20, DW2 = 32, BW2 = 4, RC2 = 1, WC2 = 2, TA2 = 0;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    exp_t q1[$];
    exp_t q2[$];

    // ---------------- instance 1 ----------------
    logic [AW1-1:0] address1;
    logic           read1, write1;
    logic [DW1-1:0] writedata1;
    logic [BW1-1:0] byteenable1;
    logic           waitreq1, rdv1;
    logic [DW1-1:0] readdata1;
    logic [AW1-1:0] s_addr1;
    logic [DW1-1:0] s_dqr1, s_dqw1;
    logic           s_dqen1, s_ce1, s_oe1, s_we1;
    logic [BW1-1:0] s_be1;

    sram_avalon_ctrl #(.AW(AW1), .DW(DW1), .READ_CYCLES(RC1), .WRITE_CYCLES(WC1), .TURNAROUND(TA1)) dut1 (
        .clk(clk), .reset(rst),
        .avs_address(address1), .avs_read(read1), .avs_write(write1),
        .avs_writedata(writedata1), .avs_byteenable(byteenable1),
        .avs_waitrequest(waitreq1), .avs_readdata(readdata1), .avs_readdatavalid(rdv1),
        .sram_addr(s_addr1), .sram_dq_read(s_dqr1), .sram_dq_write(s_dqw1), .sram_dq_en(s_dqen1),
        .sram_ce_n(s_ce1), .sram_oe_n(s_oe1), .sram_we_n(s_we1), .sram_be_n(s_be1)
    );

    logic [DW1-1:0] mem1 [0:4095];
    logic [DW1-1:0] ref1 [0:4095];
    assign s_dqr1 = (!s_ce1 && !s_oe1) ? mem1[s_addr1[11:0]] : 'x;
    always @(posedge clk)
        if (!s_ce1 && !s_we1)
            for (int b = 0; b < BW1; b++)
                if (!s_be1[b]) mem1[s_addr1[11:0]][b*8 +: 8] <= s_dqw1[b*8 +: 8];

    // ---------------- instance 2 ----------------
    logic [AW2-1:0] address2;
    logic           read2, write2;
    logic [DW2-1:0] writedata2;
    logic [BW2-1:0] byteenable2;
    logic           waitreq2, rdv2;
    logic [DW2-1:0] readdata2;
    logic [AW2-1:0] s_addr2;
    logic [DW2-1:0] s_dqr2, s_dqw2;
    logic           s_dqen2, s_ce2, s_oe2, s_we2;
    logic [BW2-1:0] s_be2;

    sram_avalon_ctrl #(.AW(AW2), .DW(DW2), .READ_CYCLES(RC2), .WRITE_CYCLES(WC2), .TURNAROUND(TA2)) dut2 (
        .clk(clk), .reset(rst),
        .avs_address(address2), .avs_read(read2), .avs_write(write2),
        .avs_writedata(writedata2), .avs_byteenable(byteenable2),
        .avs_waitrequest(waitreq2), .avs_readdata(readdata2), .avs_readdatavalid(rdv2),
        .sram_addr(s_addr2), .sram_dq_read(s_dqr2), .sram_dq_write(s_dqw2), .sram_dq_en(s_dqen2),
        .sram_ce_n(s_ce2), .sram_oe_n(s_oe2), .sram_we_n(s_we2), .sram_be_n(s_be2)
    );

    logic [DW2-1:0] mem2 [0:4095];
    logic [DW2-1:0] ref2 [0:4095];
    assign s_dqr2 = (!s_ce2 && !s_oe2) ? mem2[s_addr2[11:0]] : 'x;
    always @(posedge clk)
        if (!s_ce2 && !s_we2)
            for (int b = 0; b < BW2; b++)
                if (!s_be2[b]) mem2[s_addr2[11:0]][b*8 +: 8] <= s_dqw2[b*8 +: 8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus monitors / scoreboard pop ----------------
    logic           pw1 = 1'b0, po1 = 1'b0, pe1 = 1'b0;
    logic [AW1-1:0] pa1;
    logic [DW1-1:0] pd1;
    logic [BW1-1:0] pb1;
    int             orise1 = -1000;

    always @(negedge clk) begin
        check("d1_oe_we_overlap", 64'(!s_oe1 && !s_we1), 64'(0));
        check("d1_dqen_while_oe", 64'(s_dqen1 && !s_oe1), 64'(0));
        if (!s_we1) check("d1_dqen_during_we", 64'(s_dqen1), 64'(1));
        if (!s_we1 && pw1) begin
            check("d1_addr_stable", 64'(s_addr1), 64'(pa1));
            check("d1_data_stable", 64'(s_dqw1), 64'(pd1));
            check("d1_be_stable", 64'(s_be1), 64'(pb1));
        end
        if (s_oe1 && po1) orise1 <= cyc;
        if (s_dqen1 && !pe1) check("d1_turnaround_gap", 64'((cyc - orise1) >= TA1 + 1), 64'(1));
        if (rdv1) begin
            if (q1.size() == 0) begin
                check("d1_rdv_unexpected", 64'(rdv1), 64'(0));
            end else begin
                check("d1_rdata", 64'(readdata1), 64'(q1[0].data));
                check("d1_rd_latency", 64'(cyc - q1[0].acc), 64'(RC1 + 1));
                $display("dut1 RD-DATA data=0x%04h cyc=%0d", readdata1, cyc);
                void'(q1.pop_front());
            end
        end
        pw1 <= !s_we1; po1 <= !s_oe1; pe1 <= s_dqen1;
        pa1 <= s_addr1; pd1 <= s_dqw1; pb1 <= s_be1;
    end

    logic           pw2 = 1'b0, po2 = 1'b0, pe2 = 1'b0;
    logic [AW2-1:0] pa2;
    logic [DW2-1:0] pd2;
    int             orise2 = -1000;

    always @(negedge clk) begin
        check("d2_oe_we_overlap", 64'(!s_oe2 && !s_we2), 64'(0));
        check("d2_dqen_while_oe", 64'(s_dqen2 && !s_oe2), 64'(0));
        if (!s_we2 && pw2) begin
            check("d2_addr_stable", 64'(s_addr2), 64'(pa2));
            check("d2_data_stable", 64'(s_dqw2), 64'(pd2));
        end
        if (s_oe2 && po2) orise2 <= cyc;
        if (s_dqen2 && !pe2) check("d2_turnaround_gap", 64'((cyc - orise2) >= TA2 + 1), 64'(1));
        if (rdv2) begin
            if (q2.size() == 0) begin
                check("d2_rdv_unexpected", 64'(rdv2), 64'(0));
            end else begin
                check("d2_rdata", 64'(readdata2), 64'(q2[0].data));
                check("d2_rd_latency", 64'(cyc - q2[0].acc), 64'(RC2 + 1));
                $display("dut2 RD-DATA data=0x%08h cyc=%0d", readdata2, cyc);
                void'(q2.pop_front());
            end
        end
        pw2 <= !s_we2; po2 <= !s_oe2; pe2 <= s_dqen2;
        pa2 <= s_addr2; pd2 <= s_dqw2;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle1(input string tag);
        int n = 0;
        while (waitreq1 === 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check(tag, 64'(waitreq1), 64'(0));
    endtask

    task automatic wait_idle2(input string tag);
        int n = 0;
        while (waitreq2 === 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check(tag, 64'(waitreq2), 64'(0));
    endtask

    task automatic wr1(input logic [AW1-1:0] a, input logic [DW1-1:0] d, input logic [BW1-1:0] be,
                       input logic also_read);
        @(negedge clk);
        address1 = a; writedata1 = d; byteenable1 = be; write1 = 1'b1; read1 = also_read;
        wait_idle1("d1_wr_wait_timeout");
        for (int b = 0; b < BW1; b++) if (be[b]) ref1[a[11:0]][b*8 +: 8] = d[b*8 +: 8];
        $display("dut1 WR addr=0x%05h data=0x%04h be=%b rd=%b cyc=%0d", a, d, be, also_read, cyc);
        @(posedge clk); #1;
        write1 = 1'b0; read1 = 1'b0;
    endtask

    task automatic rd1(input logic [AW1-1:0] a);
        exp_t e;
        @(negedge clk);
        address1 = a; read1 = 1'b1;
        wait_idle1("d1_rd_wait_timeout");
        e.data = 32'(ref1[a[11:0]]); e.acc = cyc;
        q1.push_back(e);
        $display("dut1 RD addr=0x%05h expect=0x%04h cyc=%0d", a, ref1[a[11:0]], cyc);
        @(posedge clk); #1;
        read1 = 1'b0;
    endtask

    task automatic wr2(input logic [AW2-1:0] a, input logic [DW2-1:0] d, input logic [BW2-1:0] be);
        @(negedge clk);
        address2 = a; writedata2 = d; byteenable2 = be; write2 = 1'b1;
        wait_idle2("d2_wr_wait_timeout");
        for (int b = 0; b < BW2; b++) if (be[b]) ref2[a[11:0]][b*8 +: 8] = d[b*8 +: 8];
        $display("dut2 WR addr=0x%05h data=0x%08h be=%b cyc=%0d", a, d, be, cyc);
        @(posedge clk); #1;
        write2 = 1'b0;
    endtask

    task automatic rd2(input logic [AW2-1:0] a);
        exp_t e;
        @(negedge clk);
        address2 = a; read2 = 1'b1;
        wait_idle2("d2_rd_wait_timeout");
        e.data = ref2[a[11:0]]; e.acc = cyc;
        q2.push_back(e);
        $display("dut2 RD addr=0x%05h expect=0x%08h cyc=%0d", a, ref2[a[11:0]], cyc);
        @(posedge clk); #1;
        read2 = 1'b0;
    endtask

    // Counts strobe/handshake activity of instance 1 over n cycles, starting in cycle 1 after an accept.
    int             m_oe, m_we, m_en, m_wait, m_rdv, m_rdv_at;
    logic [AW1-1:0] m_addr;
    logic [DW1-1:0] m_rdata;

    task automatic measure1(input int n);
        int base = cyc - 1;
        m_oe = 0; m_we = 0; m_en = 0; m_wait = 0; m_rdv = 0; m_rdv_at = -1;
        m_addr = '0; m_rdata = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!s_oe1) begin m_oe++; m_addr = s_addr1; end
            if (!s_we1) m_we++;
            if (s_dqen1) m_en++;
            if (waitreq1) m_wait++;
            if (rdv1) begin m_rdv++; m_rdv_at = cyc - base; m_rdata = readdata1; end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        address1 = '0; read1 = 1'b0; write1 = 1'b0; writedata1 = '0; byteenable1 = '0;
        address2 = '0; read2 = 1'b0; write2 = 1'b0; writedata2 = '0; byteenable2 = '0;
        rst = 1'b1;

        // Power-on reset state
        @(negedge clk);
        check("rst_ce_n", 64'(s_ce1), 64'(1));
        check("rst_oe_n", 64'(s_oe1), 64'(1));
        check("rst_we_n", 64'(s_we1), 64'(1));
        check("rst_be_n", 64'(s_be1), 64'(2'b11));
        check("rst_dq_en", 64'(s_dqen1), 64'(0));
        check("rst_addr", 64'(s_addr1), 64'(0));
        check("rst_dq_write", 64'(s_dqw1), 64'(0));
        check("rst_readdata", 64'(readdata1), 64'(0));
        check("rst_rdv", 64'(rdv1), 64'(0));
        check("rst_waitreq", 64'(waitreq1), 64'(1));
        check("rst_be_n_32", 64'(s_be2), 64'(4'hF));
        rst = 1'b0;
        @(negedge clk);
        check("idle_waitreq", 64'(waitreq1), 64'(0));

        // Reset asserted mid-idle
        #2 rst = 1'b1;
        #1;
        check("idle_rst_waitreq", 64'(waitreq1), 64'(1));
        check("idle_rst_ce_n", 64'(s_ce1), 64'(1));
        check("idle_rst_dq_en", 64'(s_dqen1), 64'(0));
        @(negedge clk) rst = 1'b0;

        // Single full write
        wr1(18'h00012, 16'hA5C3, 2'b11, 1'b0);
        measure1(6);
        check("wr_we_low_cycles", 64'(m_we), 64'(WC1));
        check("wr_dq_en_cycles", 64'(m_en), 64'(WC1 + 1));
        check("wr_waitreq_cycles", 64'(m_wait), 64'(WC1 + 1));
        check("wr_no_oe", 64'(m_oe), 64'(0));
        check("wr_sram_content", 64'(mem1[12'h012]), 64'(16'hA5C3));

        // Byte-lane merge
        wr1(18'h00040, 16'hFFFF, 2'b11, 1'b0);
        wr1(18'h00040, 16'h1234, 2'b10, 1'b0);
        rd1(18'h00040);
        measure1(6);
        check("merge_rdata", 64'(m_rdata), 64'(16'h12FF));
        check("merge_rdv_count", 64'(m_rdv), 64'(1));

        // Read timing
        rd1(18'h00012);
        measure1(8);
        check("rd_oe_low_cycles", 64'(m_oe), 64'(RC1));
        check("rd_rdv_count", 64'(m_rdv), 64'(1));
        check("rd_rdv_offset", 64'(m_rdv_at), 64'(RC1 + 1));
        check("rd_rdata", 64'(m_rdata), 64'(16'hA5C3));
        check("rd_addr", 64'(m_addr), 64'(18'h00012));
        check("rd_waitreq_cycles", 64'(m_wait), 64'(RC1 + TA1));
        check("rd_no_dq_en", 64'(m_en), 64'(0));

        // Read followed immediately by a write; then read+write together
        rd1(18'h00012);
        wr1(18'h00013, 16'hBEEF, 2'b11, 1'b0);
        wr1(18'h00014, 16'h5555, 2'b11, 1'b1);
        measure1(6);
        check("rw_same_no_rdv", 64'(m_rdv), 64'(0));
        check("rw_same_no_oe", 64'(m_oe), 64'(0));
        check("rw_same_we_cycles", 64'(m_we), 64'(WC1));
        rd1(18'h00014);

        // Write with no byte lanes still runs a cycle but changes nothing
        wr1(18'h00013, 16'h0000, 2'b00, 1'b0);
        measure1(5);
        check("be0_we_cycles", 64'(m_we), 64'(WC1));
        rd1(18'h00013);

        // Reset in the middle of a write
        wr1(18'h00200, 16'h7777, 2'b11, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("wrcut_we_n", 64'(s_we1), 64'(1));
        check("wrcut_ce_n", 64'(s_ce1), 64'(1));
        check("wrcut_dq_en", 64'(s_dqen1), 64'(0));
        check("wrcut_be_n", 64'(s_be1), 64'(2'b11));
        @(negedge clk) rst = 1'b0;

        // Reset in the middle of a read: the pending result is abandoned
        rd1(18'h00012);
        #2 rst = 1'b1;
        q1.delete();
        #1;
        check("rdcut_oe_n", 64'(s_oe1), 64'(1));
        check("rdcut_ce_n", 64'(s_ce1), 64'(1));
        check("rdcut_rdv", 64'(rdv1), 64'(0));
        @(negedge clk) rst = 1'b0;
        measure1(5);
        check("rdcut_no_rdv", 64'(m_rdv), 64'(0));
        rd1(18'h00012);

        // Wide variant, zero turnaround: fill a pool then random traffic
        for (int i = 0; i < 32; i++) wr2(20'(20'h00A00 + i), 32'($urandom), 4'hF);
        rd2(20'h00A05);
        wr2(20'h00A06, 32'hCAFE_F00D, 4'hF);
        for (int n = 0; n < 300; n++) begin
            logic [AW2-1:0] a;
            a = 20'(20'h00A00 + $urandom_range(0, 31));
            if ($urandom_range(0, 2) == 2) rd2(a);
            else wr2(a, 32'($urandom), 4'($urandom_range(0, 15)));
        end

        repeat (10) @(negedge clk);
        check("q1_drained", 64'(q1.size()), 64'(0));
        check("q2_drained", 64'(q2.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
